// File: rtl/mix_wt_updater.sv
// Mix-layer weight updater: streams weights and gradients and writes back w - (g >>> LR_SHIFT).
// Optional per-lane saturation of the result is enabled by defining MIX_WT_UPD_SAT_EN.
`ifndef HID_DIM
`define HID_DIM 8
`endif
`ifndef DATA_N
`define DATA_N 4
`endif
`ifndef N_LEN_W
`define N_LEN_W 8
`endif

module mix_wt_lane #(
  parameter int W        = 8,
  parameter int LR_SHIFT = 6
) (
  input  logic [W-1:0] w,
  input  logic [W-1:0] g,
  output logic [W-1:0] q
);
  logic signed [W-1:0] delta;
  assign delta = $signed(g) >>> LR_SHIFT;

`ifdef MIX_WT_UPD_SAT_EN
  logic signed [W:0] diff;
  assign diff = $signed({w[W-1], w}) - $signed({delta[W-1], delta});
  // Top two bits disagree only when the result left the W-bit range.
  assign q = (diff[W] != diff[W-1]) ? (diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                                    : diff[W-1:0];
`else
  assign q = w - delta;
`endif
endmodule

module mix_wt_updater #(
  parameter int ADDR_WIDTH = 9,
  parameter int MAT_WORDS  = `HID_DIM * `HID_DIM / `DATA_N,
  parameter int DATA_WIDTH = `DATA_N * `N_LEN_W,
  parameter int LR_SHIFT   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [1:0]            mat_sel,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] wt_rdata,
  input  logic [DATA_WIDTH-1:0] grad_rdata,
  output logic                  load,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata
);
  localparam int NUM_LANES = `DATA_N;
  localparam int LANE_W    = `N_LEN_W;
  localparam int STAGES    = 1;
  localparam logic [ADDR_WIDTH-1:0] MW = ADDR_WIDTH'(MAT_WORDS);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] base, last, idx, addr_d;
  logic                  drain_cnt, rd_vld;
  logic [STAGES:0]       vld_pipe;

  logic [NUM_LANES-1:0][LANE_W-1:0] w_lanes, g_lanes, q_lanes;
  assign w_lanes = wt_rdata;
  assign g_lanes = grad_rdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mix_wt_lane #(.W(LANE_W), .LR_SHIFT(LR_SHIFT)) u_lane (
      .w(w_lanes[i]),
      .g(g_lanes[i]),
      .q(q_lanes[i])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (run) state_nx = READ;
      READ:    if (idx == last) state_nx = DRAIN;
      DRAIN:   if (drain_cnt) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign rd_vld = (state == READ);
  assign raddr  = rd_vld ? base + idx : '0;
  assign busy   = (state == READ) || (state == DRAIN);
  assign done   = (state == DONE);
  assign load   = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      last      <= '0;
      idx       <= '0;
      drain_cnt <= 1'b0;
      vld_pipe  <= '0;
      addr_d    <= '0;
      waddr     <= '0;
      wdata     <= '0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (state == IDLE && run) begin
        base <= (mat_sel == 2'd3) ? '0 : ADDR_WIDTH'(mat_sel) * MW;
        last <= (mat_sel == 2'd3) ? 3 * MW - 1'b1 : MW - 1'b1;
        idx  <= '0;
      end else if (rd_vld) begin
        idx <= idx + 1'b1;
      end
      // Stage A -> B: RAM data arrives one cycle after raddr.
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_vld};
      addr_d   <= raddr;
      waddr    <= addr_d;
      if (vld_pipe[0]) wdata <= q_lanes;
    end
  end
endmodule

// File: tb/tb_mix_wt_updater.sv
// Directed bench for mix_wt_updater with a bench-side weight/gradient RAM pair.
`ifndef HID_DIM
`define HID_DIM 8
`endif
`ifndef DATA_N
`define DATA_N 4
`endif
`ifndef N_LEN_W
`define N_LEN_W 8
`endif

module tb_mix_wt_updater;
  localparam int AW = 9;
  localparam int MW = `HID_DIM * `HID_DIM / `DATA_N;
  localparam int DW = `DATA_N * `N_LEN_W;

  logic          clk = 1'b0;
  logic          rst, run;
  logic [1:0]    mat_sel;
  logic          busy, done, load;
  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] wt_rdata, grad_rdata, wdata;

  logic [DW-1:0] wt_mem [0:511];
  logic [DW-1:0] gr_mem [0:511];
  logic          fill_en = 1'b0, poke_en = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [DW-1:0] set_w = '0, set_g = '0;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  mix_wt_updater #(.ADDR_WIDTH(AW), .MAT_WORDS(MW), .DATA_WIDTH(DW), .LR_SHIFT(6)) dut (
    .clk(clk), .rst(rst), .run(run), .mat_sel(mat_sel), .busy(busy), .done(done),
    .raddr(raddr), .wt_rdata(wt_rdata), .grad_rdata(grad_rdata),
    .load(load), .waddr(waddr), .wdata(wdata)
  );

  always @(posedge clk) begin
    wt_rdata   <= wt_mem[raddr];
    grad_rdata <= gr_mem[raddr];
    if (fill_en) begin
      for (int j = 0; j < 512; j++) begin
        wt_mem[j] <= set_w;
        gr_mem[j] <= set_g;
      end
    end else if (poke_en) begin
      wt_mem[poke_a] <= set_w;
      gr_mem[poke_a] <= set_g;
    end else if (load) begin
      wt_mem[waddr] <= wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [DW-1:0] w, input logic [DW-1:0] g);
    @(negedge clk); set_w = w; set_g = g; fill_en = 1'b1;
    @(negedge clk); fill_en = 1'b0;
  endtask

  task automatic poke(input int a, input logic [DW-1:0] w, input logic [DW-1:0] g);
    @(negedge clk); poke_a = AW'(a); set_w = w; set_g = g; poke_en = 1'b1;
    @(negedge clk); poke_en = 1'b0;
  endtask

  task automatic check_mem(input int lo, input int hi, input logic [DW-1:0] exp);
    for (int j = lo; j <= hi; j++) chk($sformatf("mem[%0d]", j), wt_mem[j], exp);
  endtask

  // Pulse run with sel, then walk the pass cycle by cycle from c=1 (cycle after the sampling edge).
  task automatic do_pass(input logic [1:0] sel, input int n, input int base,
                         input int pulse_at, input int rst_at);
    int loads = 0, dones = 0;
    bit e_busy, e_load, e_done;
    int e_raddr;
    @(negedge clk); run = 1'b1; mat_sel = sel;
    @(negedge clk); run = 1'b0; mat_sel = sel ^ 2'b01;
    for (int c = 1; c <= n + 5; c++) begin
      loads += int'(load);
      dones += int'(done);
      if (rst_at > 0 && c > rst_at) begin
        chk("rst_busy", busy, 0);  chk("rst_load", load, 0);  chk("rst_done", done, 0);
        chk("rst_raddr", raddr, 0); chk("rst_waddr", waddr, 0); chk("rst_wdata", wdata, 0);
      end else begin
        e_busy  = (c >= 1 && c <= n + 2);
        e_load  = (c >= 3 && c <= n + 2);
        e_done  = (c == n + 3);
        e_raddr = (c <= n) ? base + c - 1 : 0;
        chk($sformatf("busy c%0d", c), busy, e_busy);
        chk($sformatf("load c%0d", c), load, e_load);
        chk($sformatf("done c%0d", c), done, e_done);
        chk($sformatf("raddr c%0d", c), raddr, e_raddr);
        if (e_load) chk($sformatf("waddr c%0d", c), waddr, base + c - 3);
      end
      run = (c == pulse_at);
      rst = (c == rst_at);
      @(negedge clk);
    end
    run = 1'b0; rst = 1'b0;
    chk("load_count", loads, (rst_at > 0) ? rst_at - 2 : n);
    chk("done_count", dones, (rst_at > 0) ? 0 : 1);
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; mat_sel = 2'd3;
    repeat (3) begin
      @(negedge clk);
      chk("reset_busy", busy, 0);   chk("reset_done", done, 0);  chk("reset_load", load, 0);
      chk("reset_raddr", raddr, 0); chk("reset_waddr", waddr, 0); chk("reset_wdata", wdata, 0);
    end
    rst = 1'b0; run = 1'b0;

    // W_2 only: 5 - (64 >>> 6) = 4 in every lane
    fill(32'h05050505, 32'h40404040);
    do_pass(2'd1, MW, MW, 0, 0);
    check_mem(0, MW - 1, 32'h05050505);
    check_mem(MW, 2 * MW - 1, 32'h04040404);
    check_mem(2 * MW, 3 * MW - 1, 32'h05050505);

    // Floor shift and range edges on W_1
    fill(32'h05050505, 32'h40404040);
    poke(0, 32'h07070707, 32'hFFFFFFFF);
    poke(1, 32'h80808080, 32'h7F7F7F7F);
    poke(2, 32'h7F7F7F7F, 32'h80808080);
    poke(3, 32'h0AFD0064, 32'h7FC00081);
    do_pass(2'd0, MW, 0, 0, 0);
    chk("neg_grad", wt_mem[0], 32'h08080808);
`ifdef MIX_WT_UPD_SAT_EN
    chk("sat_low", wt_mem[1], 32'h80808080);
    chk("sat_high", wt_mem[2], 32'h7F7F7F7F);
`else
    chk("wrap_low", wt_mem[1], 32'h7F7F7F7F);
    chk("wrap_high", wt_mem[2], 32'h81818181);
`endif
    chk("mixed_lanes", wt_mem[3], 32'h09FE0066);
    check_mem(4, MW - 1, 32'h04040404);
    check_mem(MW, 3 * MW - 1, 32'h05050505);

    // All three matrices, with a stray run pulse mid-pass
    fill(32'h05050505, 32'h40404040);
    do_pass(2'd3, 3 * MW, 0, 10, 0);
    check_mem(0, 3 * MW - 1, 32'h04040404);

    // Reset during the 10th READ cycle, then a clean rerun of W_1
    fill(32'h05050505, 32'h40404040);
    do_pass(2'd0, MW, 0, 0, 10);
    check_mem(0, 7, 32'h04040404);
    check_mem(8, MW - 1, 32'h05050505);
    do_pass(2'd0, MW, 0, 0, 0);
    check_mem(0, 7, 32'h03030303);
    check_mem(8, MW - 1, 32'h04040404);
    check_mem(MW, MW + 4, 32'h05050505);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mix_wt_updater.md
# mix_wt_updater

Weight-update engine for the mix layer's block-RAM weight store. On a start pulse it streams one or all three mix-layer weight matrices (W_1, W_2, W_3) out of the weight RAM and the matching words out of the gradient RAM. It applies a per-lane fixed-point SGD step, w_new = w − (g >>> LR_SHIFT), and writes each result back through the weight RAM's load port. It sits directly upstream of the weight RAM's write side, and its address output also drives the RAM read side while it is busy.

## Interface
- ADDR_WIDTH, 9, address width of the weight and gradient RAMs.
- MAT_WORDS, `HID_DIM*`HID_DIM/`DATA_N, words per matrix.
- DATA_WIDTH, `DATA_N*`N_LEN_W, RAM word width; `DATA_N lanes of `N_LEN_W bits.
- LR_SHIFT, 6, learning-rate right shift, 0..`N_LEN_W-1.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start pulse; sampled only in IDLE.
- mat_sel  in  2  matrix select: 0 = W_1, 1 = W_2, 2 = W_3, 3 = all three; sampled with run.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse after the last write.
- raddr  out  ADDR_WIDTH  read address to both the weight RAM and the gradient RAM.
- wt_rdata  in  DATA_WIDTH  weight RAM read data; 1-cycle registered latency.
- grad_rdata  in  DATA_WIDTH  gradient RAM read data; same latency and addressing.
- load  out  1  weight RAM write enable.
- waddr  out  ADDR_WIDTH  write address.
- wdata  out  DATA_WIDTH  updated weight word.

## Operation
- FSM states:
  - IDLE: run=1 → READ. The block latches base = mat_sel*MAT_WORDS (0 for mat_sel=3) and count N = MAT_WORDS, or 3*MAT_WORDS for mat_sel=3.
  - READ: raddr = base+i for i = 0..N−1, one word per cycle. After i = N−1 → DRAIN.
  - DRAIN: two cycles emptying the pipeline → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Pipeline:
  - Stage A: raddr issued.
  - Stage B: wt_rdata and grad_rdata valid; lane math computed; result registered into wdata.
  - waddr is raddr delayed by 2 cycles; load is the read-valid flag delayed by 2 cycles.
- Lane i occupies bits [i*`N_LEN_W +: `N_LEN_W]. Operands are signed two's complement.
  - delta = g >>> LR_SHIFT (arithmetic shift, floors toward −∞).
  - diff = w − delta, computed at `N_LEN_W+1 bits, then reduced to `N_LEN_W bits as set by Configuration.
- Each address is read exactly once and written 2 cycles later, so there is no read-after-write hazard.
- run while busy or in DONE is ignored. mat_sel changes mid-pass have no effect.
- raddr holds 0 outside READ.
- rst at any state → IDLE on the next edge. No done is issued. Partially written words stay written. The next run restarts from base.
- Reset values: busy=0, done=0, raddr=0, load=0, waddr=0, wdata=0.

## Timing
- run sampled high at edge k: busy=1 in cycles k+1..k+N+2.
- raddr valid in cycles k+1..k+N.
- load=1 in cycles k+3..k+N+2.
- done=1 in cycle k+N+3.
- Throughput: 1 word/cycle. Pass length is N+3 cycles after run.
- rst sampled at edge r: all outputs are at reset values from cycle r+1.

## Configuration
- MIX_WT_UPD_SAT_EN defined: diff is clamped to [−2^(`N_LEN_W−1), 2^(`N_LEN_W−1)−1] per lane.
- MIX_WT_UPD_SAT_EN undefined: diff is truncated to its low `N_LEN_W bits (wrap-around). This removes the per-lane comparators.

## Test plan
- Reset: hold rst 3 cycles with run=1 → all outputs 0, no load, no done.
- mat_sel=1, all grad lanes = 64, LR_SHIFT=6, weights = 5 → every word in MAT_WORDS..2*MAT_WORDS−1 becomes lanes of 4. Other matrices unchanged. First load at k+3; done at k+MAT_WORDS+3.
- Negative gradient: g = −1, LR_SHIFT=6 → delta = −1, weight 7 becomes 8 (floor shift).
- Saturation: w = −2^(`N_LEN_W−1), g = 2^(`N_LEN_W−2), LR_SHIFT=0 → with SAT_EN, result is the min value. Without SAT_EN, result is the wrapped value 2^(`N_LEN_W−1)−2^(`N_LEN_W−2).
- mat_sel=3 full pass → exactly 3*MAT_WORDS load cycles at addresses 0..3*MAT_WORDS−1 in order. A run pulse mid-pass is ignored. done occurs once.
- rst asserted at the 10th READ cycle → load=0 next cycle, no done. A fresh run with mat_sel=0 rewrites from address 0.
